// File: rtl/sap2_io_pkg.sv
// sap2_io_pkg
//   Shared definitions for the SAP-2 I/O port blocks: serial tx state
//   encoding, default port numbers and the serial frame length.
package sap2_io_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam logic [7:0] PORT3_DEFAULT = 8'h03;
   localparam logic [7:0] PORT4_DEFAULT = 8'h04;

   // start + 8 data + stop
   localparam int FRAME_BITS = 10;

endpackage

// File: rtl/sap2_output_port_if.sv
// sap2_output_port_if
//   Bus between the SAP-2 controller side and the output-port responder.
//   Ports:
//     iBus      W-bus data during OUT
//     iPortSel  port byte of the OUT instruction
//     iLo       output-load strobe, one cycle per OUT
//     iAck      port-3 device acknowledge (level)
//     oPort3    port-3 parallel data
//     oReady3   port-3 holds unconsumed data
//     oSerial   port-4 serial line, idles high
//     oBusy     either port occupied
//     oErr      one-cycle pulse: OUT dropped, target port busy
//   Modports: master = sequencer/testbench side, slave = responder side.
interface sap2_output_port_if;

   logic [7:0] iBus;
   logic [7:0] iPortSel;
   logic       iLo;
   logic       iAck;
   logic [7:0] oPort3;
   logic       oReady3;
   logic       oSerial;
   logic       oBusy;
   logic       oErr;

   modport master (
      output iBus, iPortSel, iLo, iAck,
      input  oPort3, oReady3, oSerial, oBusy, oErr
   );

   modport slave (
      input  iBus, iPortSel, iLo, iAck,
      output oPort3, oReady3, oSerial, oBusy, oErr
   );

endinterface

// File: rtl/sap2_serial_tx.sv
// sap2_serial_tx
//   Port-4 serial transmitter: 8N1 frame, LSB first, BAUD_DIV clocks/bit.
//   Ports:
//     i_clk, i_rst_n  clock / async active-low reset
//     i_load, i_data  start a frame with i_data (taken only when o_ready)
//     o_line          registered serial line, idles high
//     o_busy          FSM not in IDLE
//     o_ready         a load this cycle would be accepted
//
//   state | meaning
//   ------+------------------------------------------
//   IDLE  | line high, waiting for a load
//   START | line low for one bit time
//   DATA  | shifting out 8 bits, LSB first
//   STOP  | line high for one bit time
module sap2_serial_tx
   import sap2_io_pkg::*;
#(
   parameter int BAUD_DIV = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_load,
   input  logic [7:0] i_data,
   output logic       o_line,
   output logic       o_busy,
   output logic       o_ready
);

   localparam int             BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);

   tx_state_t     r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_line;

   logic w_baud_end;

   assign w_baud_end = (r_baud == BAUD_LAST);

   // The last stop-bit cycle also accepts a load so frames can run
   // back to back with no idle cycle between them.
   assign o_ready = (r_state == IDLE) || ((r_state == STOP) && w_baud_end);
   assign o_busy  = (r_state != IDLE);
   assign o_line  = r_line;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_line  <= 1'b1;
      end else if (i_load && o_ready) begin
         r_state <= START;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= i_data;
         r_line  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_line <= 1'b1;
            end
            START: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_state <= DATA;
                  r_line  <= r_shift[0];
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            DATA: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  // 3-bit counter wraps 7 -> 0 on entry to STOP
                  r_bit  <= r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
                     r_state <= STOP;
                     r_line  <= 1'b1;
                  end else begin
                     r_shift <= r_shift >> 1;
                     r_line  <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            STOP: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_state <= IDLE;
                  r_line  <= 1'b1;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_line  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/sap2_output_port.sv
// sap2_output_port
//   SAP-2 OUT-instruction responder. Decodes the port byte on the output
//   load strobe and delivers the W-bus value to port 3 (parallel with
//   ready/ack handshake) or port 4 (serial transmitter).
//   Ports:
//     inCLK    system clock
//     inRST    async active-low reset
//     if_port  slave side of sap2_output_port_if (bus, strobe, ack, outputs)
module sap2_output_port
   import sap2_io_pkg::*;
#(
   parameter int         BAUD_DIV = 4,
   parameter logic [7:0] PORT3    = PORT3_DEFAULT,
   parameter logic [7:0] PORT4    = PORT4_DEFAULT
) (
   input  logic                 inCLK,
   input  logic                 inRST,
   sap2_output_port_if.slave    if_port
);

   logic [7:0] r_port3;
   logic       r_ready3;
   logic       r_err;

   logic w_sel3;
   logic w_sel4;
   logic w_tx_busy;
   logic w_tx_ready;
   logic w_tx_line;

   assign w_sel3 = if_port.iLo && (if_port.iPortSel == PORT3);
   assign w_sel4 = if_port.iLo && (if_port.iPortSel == PORT4);

   always_ff @(posedge inCLK or negedge inRST) begin
      if (!inRST) begin
         r_port3  <= '0;
         r_ready3 <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_err <= (w_sel3 && r_ready3) || (w_sel4 && !w_tx_ready);
         // A rejected write does not block an ack in the same cycle.
         if (w_sel3 && !r_ready3) begin
            r_port3  <= if_port.iBus;
            r_ready3 <= 1'b1;
         end else if (r_ready3 && if_port.iAck) begin
            r_ready3 <= 1'b0;
         end
      end
   end

   sap2_serial_tx #(
      .BAUD_DIV (BAUD_DIV)
   ) u_tx (
      .i_clk   (inCLK),
      .i_rst_n (inRST),
      .i_load  (w_sel4),
      .i_data  (if_port.iBus),
      .o_line  (w_tx_line),
      .o_busy  (w_tx_busy),
      .o_ready (w_tx_ready)
   );

   assign if_port.oPort3  = r_port3;
   assign if_port.oReady3 = r_ready3;
   assign if_port.oSerial = w_tx_line;
   assign if_port.oBusy   = r_ready3 | w_tx_busy;
   assign if_port.oErr    = r_err;

endmodule

// File: doc/sap2_output_port.md
# sap2_output_port

Output-port responder for the SAP-2 machine: executes the `OUT byte` instruction issued by the controller-sequencer. On the sequencer's output-load strobe it captures the W-bus (accumulator) value and delivers it to one of two ports. Port 3 is a parallel port with a ready/acknowledge handshake; port 4 is a serial transmitter. Sits on the datapath side of the control word, beside the accumulator and the output register.

## Interface
- `BAUD_DIV`, 4: clock cycles per serial bit; legal range ≥ 2.
- `PORT3`, 8'h03: port number of the parallel handshake port.
- `PORT4`, 8'h04: port number of the serial port.

- `inCLK`  input  1  system clock; all state changes on the rising edge.
- `inRST`  input  1  reset; asynchronous, active-low.
- `iBus`  input  8  W-bus data (accumulator contents during `OUT`).
- `iPortSel`  input  8  port byte of the `OUT` instruction.
- `iLo`  input  1  output-load strobe from the sequencer; one cycle per `OUT`.
- `iAck`  input  1  external device acknowledge for port 3; level-sensitive.
- `oPort3`  output  8  port 3 parallel data.
- `oReady3`  output  1  port 3 holds unconsumed data.
- `oSerial`  output  1  port 4 serial line; idles high.
- `oBusy`  output  1  `oReady3 | (tx state != IDLE)`.
- `oErr`  output  1  one-cycle pulse: `OUT` was dropped because the target port was busy.

## Operation
- Reset (async assert) values: `oPort3`=0, `oReady3`=0, `oSerial`=1, `oBusy`=0, `oErr`=0. Tx FSM is `IDLE`; bit and baud counters are 0.
- Port 3:
  - `iLo` with `iPortSel==PORT3` and `oReady3==0`: latch `iBus` into `oPort3` and set `oReady3`.
  - While `oReady3==1`, sampling `iAck==1` clears `oReady3`. `oPort3` keeps its value until the next accepted write.
  - `iLo` to PORT3 while `oReady3==1` is dropped and `oErr` pulses, even if `iAck` is high in the same cycle. That `iAck` still clears `oReady3`.
- Port 4, tx FSM:
  - States: `IDLE` → `START` → `DATA` → `STOP` → `IDLE`.
  - `iLo` with `iPortSel==PORT4` in `IDLE`: load the shift register with `iBus` and go to `START`.
  - `START` drives 0 for `BAUD_DIV` cycles.
  - `DATA` drives 8 bits, LSB first, `BAUD_DIV` cycles each. The bit counter runs 0..7 and wraps into `STOP`.
  - `STOP` drives 1 for `BAUD_DIV` cycles, then returns to `IDLE`.
  - `iLo` to PORT4 when not `IDLE` is dropped and `oErr` pulses; the frame in progress is unaffected.
- Any other `iPortSel` value: `iLo` is ignored and `oErr` stays 0.
- Ports 3 and 4 are independent; a port-3 handshake may overlap a port-4 frame.
- Reset mid-frame: `oSerial` returns to 1 immediately and any partial frame is abandoned. Reset mid-handshake: `oReady3` drops immediately.

## Timing
- Every output is registered; nothing is combinational from the inputs except `oBusy`, which is decoded from registers.
- Port 3 write: `iLo` sampled at edge k → `oPort3`/`oReady3` valid after edge k.
- Port 3 acknowledge: `iAck` sampled at edge m → `oReady3` low after edge m. An accepted `iLo` is possible at edge m+1.
- `oErr`: high for exactly the cycle after the rejecting edge.
- Port 4 frame from `iLo` at edge k:
  - Start bit occupies cycles after edges k .. k+B−1, where B = `BAUD_DIV`.
  - Data bit i occupies cycles after edges k+B(1+i) .. k+B(2+i)−1.
  - Stop bit ends at edge k+10B, which returns the FSM to `IDLE`.
  - Earliest next accepted `iLo` to PORT4 is edge k+10B, giving back-to-back frames with no extra idle cycle.
- Baud counter width: `$clog2(BAUD_DIV)`. It counts 0..B−1 and wraps.

## Structure
- Shared package `sap2_io_pkg` holds:
  - the tx state enum (`IDLE`, `START`, `DATA`, `STOP`);
  - default port constants 8'h03/8'h04 (also used by the input-port block);
  - the frame length constant 10.
- Sub-module `sap2_serial_tx` contains the FSM, baud counter, bit counter and shift register. Its interface is load/data in and line/busy out.
- The top level holds the address decode, the port-3 handshake register and `oErr`.

## Test plan
- Reset release (`BAUD_DIV`=4): `oSerial`=1, `oReady3`=0, `oPort3`=0, `oBusy`=0 on the first cycle.
- Port 3: `iLo`, `iPortSel`=8'h03, `iBus`=8'hA5 → `oPort3`=A5 and `oReady3`=1 the next cycle. `iAck` pulsed 3 cycles later → `oReady3`=0 the following cycle, `oPort3` stays A5.
- Port 3 overrun: second `iLo` to 03 with `iBus`=8'h3C before `iAck` → `oErr` one-cycle pulse, `oPort3` stays A5. After the ack, writing 3C succeeds.
- Port 4: `iLo` to 04 with `iBus`=8'h53 → line waveform 0,1,1,0,0,1,0,1,0,1, each bit 4 cycles long (40 cycles total). `oBusy` high for the full frame.
- Port 4 busy: second `iLo` to 04 at cycle 10 of the frame → `oErr` pulses and the waveform is unchanged. `iLo` at the frame-ending edge is accepted with no idle gap.
- Edge cases:
  - `iLo` with `iPortSel`=8'h05 → no output change and no `oErr`.
  - `inRST` asserted at cycle 17 of a frame → `oSerial`=1 immediately.
  - After release, a new frame transmits correctly.
